// File: rtl/axi_analysis.sv
// Receive-side L4 classifier: parses IPv4 + UDP/TCP headers from a 32-bit stream, captures payload, emits one record.
// States: HDR parse headers | PAYLOAD capture bytes | DROP discard to tlast | OUT hold record until taken
module axi_analysis #(
    parameter int DATA_W      = 32,
    parameter int MAX_PAYLOAD = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     io_in_tvalid,
    output logic                     io_in_tready,
    input  logic [DATA_W-1:0]        io_in_tdata,
    input  logic [DATA_W/8-1:0]      io_in_tkeep,
    input  logic [DATA_W/8-1:0]      io_in_tstrb,
    input  logic                     io_in_tlast,
    input  logic [3:0]               io_in_tid,
    input  logic [3:0]               io_in_tdest,
    input  logic [3:0]               io_in_tuser,
    input  logic                     io_out_udp_ready,
    output logic                     io_out_udp_valid,
    output logic [8*MAX_PAYLOAD-1:0] io_out_udp_bits_data,
    output logic [15:0]              io_out_udp_bits_len,
    output logic [15:0]              io_out_udp_bits_udp_head_src_port,
    output logic [15:0]              io_out_udp_bits_udp_head_dst_port,
    output logic [15:0]              io_out_udp_bits_udp_head_length,
    output logic [15:0]              io_out_udp_bits_udp_head_checksum,
    input  logic                     io_out_tcp_ready,
    output logic                     io_out_tcp_valid,
    output logic [8*MAX_PAYLOAD-1:0] io_out_tcp_bits_data,
    output logic [15:0]              io_out_tcp_bits_len
);
    localparam int KW    = DATA_W / 8;
    localparam int BUF_W = 8 * MAX_PAYLOAD;
    localparam int LEN_W = $clog2(MAX_PAYLOAD + 1);

    typedef enum logic [1:0] {S_HDR, S_PAYLOAD, S_DROP, S_OUT} state_t;

    state_t             state_q;
    logic [5:0]         w_q;
    logic [3:0]         ihl_q, doff_q;
    logic               is_tcp_q;
    logic [15:0]        src_q, dst_q, ulen_q, csum_q;
    logic [BUF_W-1:0]   data_q, data_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               udp_valid_q, tcp_valid_q;

    logic               beat, hdr_end, hdr_bad, rec_taken;
    logic [5:0]         ihl_w, doff_w;
    logic               unused_ok;

    assign unused_ok = ^{io_in_tstrb, io_in_tid, io_in_tdest, io_in_tuser};

    assign io_in_tready = (state_q != S_OUT);
    assign beat         = io_in_tvalid && io_in_tready;
    assign ihl_w        = {2'b00, ihl_q};
    assign doff_w       = {2'b00, doff_q};
    assign rec_taken    = (udp_valid_q && io_out_udp_ready) || (tcp_valid_q && io_out_tcp_ready);

    // ihl_q/is_tcp_q/doff_q are only trusted once the word that defines them has gone by
    assign hdr_end = is_tcp_q ? (w_q > ihl_w + 6'd3 && w_q == ihl_w + doff_w - 6'd1)
                              : (w_q >= 6'd3 && w_q == ihl_w + 6'd1);

    assign hdr_bad = (w_q == 6'd0 && (io_in_tdata[31:28] != 4'd4 || io_in_tdata[27:24] < 4'd5))
                  || (w_q == 6'd2 && io_in_tdata[23:16] != 8'd17 && io_in_tdata[23:16] != 8'd6)
                  || (is_tcp_q && w_q >= 6'd3 && w_q == ihl_w + 6'd3 && io_in_tdata[31:28] < 4'd5);

    // tkeep is contiguous from the MSB lane, so bytes land at consecutive positions
    always_comb begin
        data_d = data_q;
        len_d  = len_q;
        for (int k = 0; k < KW; k++) begin
            if (io_in_tkeep[KW-1-k] && len_d < LEN_W'(MAX_PAYLOAD)) begin
                data_d[BUF_W-1-8*int'(len_d) -: 8] = io_in_tdata[DATA_W-1-8*k -: 8];
                len_d = len_d + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_HDR;
            w_q         <= '0;
            ihl_q       <= '0;
            doff_q      <= '0;
            is_tcp_q    <= 1'b0;
            src_q       <= '0;
            dst_q       <= '0;
            ulen_q      <= '0;
            csum_q      <= '0;
            data_q      <= '0;
            len_q       <= '0;
            udp_valid_q <= 1'b0;
            tcp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_HDR: if (beat) begin
                    w_q <= w_q + 6'd1;
                    if (w_q == 6'd0) ihl_q <= io_in_tdata[27:24];
                    if (w_q == 6'd2) is_tcp_q <= (io_in_tdata[23:16] == 8'd6);
                    if (!is_tcp_q && w_q >= 6'd3 && w_q == ihl_w) begin
                        src_q <= io_in_tdata[31:16];
                        dst_q <= io_in_tdata[15:0];
                    end
                    if (!is_tcp_q && w_q >= 6'd3 && w_q == ihl_w + 6'd1) begin
                        ulen_q <= io_in_tdata[31:16];
                        csum_q <= io_in_tdata[15:0];
                    end
                    if (is_tcp_q && w_q >= 6'd3 && w_q == ihl_w + 6'd3) doff_q <= io_in_tdata[31:28];
                    if (io_in_tlast) begin
                        w_q <= '0;
                        if (hdr_end) begin
                            state_q     <= S_OUT;
                            udp_valid_q <= !is_tcp_q;
                            tcp_valid_q <= is_tcp_q;
                        end
                    end else if (hdr_bad) begin
                        w_q     <= '0;
                        state_q <= S_DROP;
                    end else if (hdr_end) begin
                        w_q     <= '0;
                        state_q <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: if (beat) begin
                    data_q <= data_d;
                    len_q  <= len_d;
                    if (io_in_tlast) begin
                        state_q     <= S_OUT;
                        udp_valid_q <= !is_tcp_q;
                        tcp_valid_q <= is_tcp_q;
                    end
                end
                S_DROP: if (beat && io_in_tlast) state_q <= S_HDR;
                S_OUT: if (rec_taken) begin
                    udp_valid_q <= 1'b0;
                    tcp_valid_q <= 1'b0;
                    data_q      <= '0;
                    len_q       <= '0;
                    state_q     <= S_HDR;
                end
                default: state_q <= S_HDR;
            endcase
        end
    end

    assign io_out_udp_valid                  = udp_valid_q;
    assign io_out_udp_bits_data              = data_q;
    assign io_out_udp_bits_len               = 16'(len_q);
    assign io_out_udp_bits_udp_head_src_port = src_q;
    assign io_out_udp_bits_udp_head_dst_port = dst_q;
    assign io_out_udp_bits_udp_head_length   = ulen_q;
    assign io_out_udp_bits_udp_head_checksum = csum_q;
    assign io_out_tcp_valid                  = tcp_valid_q;
    assign io_out_tcp_bits_data              = data_q;
    assign io_out_tcp_bits_len               = 16'(len_q);
endmodule

// File: tb/tb_axi_analysis.sv
// Directed bench for axi_analysis: packet table built from header/payload recipes, plus drop and reset sequences.
module tb_axi_analysis;
    logic         clock = 1'b0;
    logic         reset;
    logic         io_in_tvalid, io_in_tready, io_in_tlast;
    logic [31:0]  io_in_tdata;
    logic [3:0]   io_in_tkeep, io_in_tstrb, io_in_tid, io_in_tdest, io_in_tuser;
    logic         io_out_udp_ready, io_out_udp_valid;
    logic [511:0] io_out_udp_bits_data;
    logic [15:0]  io_out_udp_bits_len;
    logic [15:0]  udp_src, udp_dst, udp_length, udp_csum;
    logic         io_out_tcp_ready, io_out_tcp_valid;
    logic [511:0] io_out_tcp_bits_data;
    logic [15:0]  io_out_tcp_bits_len;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    axi_analysis dut (
        .clock(clock), .reset(reset),
        .io_in_tvalid(io_in_tvalid), .io_in_tready(io_in_tready), .io_in_tdata(io_in_tdata),
        .io_in_tkeep(io_in_tkeep), .io_in_tstrb(io_in_tstrb), .io_in_tlast(io_in_tlast),
        .io_in_tid(io_in_tid), .io_in_tdest(io_in_tdest), .io_in_tuser(io_in_tuser),
        .io_out_udp_ready(io_out_udp_ready), .io_out_udp_valid(io_out_udp_valid),
        .io_out_udp_bits_data(io_out_udp_bits_data), .io_out_udp_bits_len(io_out_udp_bits_len),
        .io_out_udp_bits_udp_head_src_port(udp_src), .io_out_udp_bits_udp_head_dst_port(udp_dst),
        .io_out_udp_bits_udp_head_length(udp_length), .io_out_udp_bits_udp_head_checksum(udp_csum),
        .io_out_tcp_ready(io_out_tcp_ready), .io_out_tcp_valid(io_out_tcp_valid),
        .io_out_tcp_bits_data(io_out_tcp_bits_data), .io_out_tcp_bits_len(io_out_tcp_bits_len)
    );

    typedef struct {
        logic [3:0]  version, ihl;
        logic [7:0]  proto;
        logic [3:0]  doff;
        int          n_pay;
        bit          mode;
        logic [7:0]  seed;
        bit          use_fw;
        logic [31:0] fw;
        int          hold, cut;
        bit          exp_udp, exp_tcp;
        int          exp_len;
    } vec_t;

    vec_t tab [16];

    function automatic vec_t mk(input logic [3:0] ver, input logic [3:0] ihl, input logic [7:0] proto,
                                input logic [3:0] doff, input int n, input bit mode, input logic [7:0] seed,
                                input bit use_fw, input logic [31:0] fw, input int hold, input int cut,
                                input bit eu, input bit et, input int el);
        vec_t r;
        r.version = ver; r.ihl = ihl; r.proto = proto; r.doff = doff; r.n_pay = n;
        r.mode = mode; r.seed = seed; r.use_fw = use_fw; r.fw = fw; r.hold = hold; r.cut = cut;
        r.exp_udp = eu; r.exp_tcp = et; r.exp_len = el;
        return r;
    endfunction

    function automatic logic [7:0] pay_byte(input vec_t r, input int k);
        if (r.use_fw && k < 4) return r.fw[31-8*k -: 8];
        else if (r.mode) return r.seed ^ 8'(k * 17);
        else return r.seed + 8'(k);
    endfunction

    function automatic logic [31:0] hdr_word(input vec_t r, input int j, input int idx);
        int ihl = int'(r.ihl);
        if (j == 0) return {r.version, r.ihl, 8'h00, 16'h0000};
        if (j == 1) return 32'h0000_4000;
        if (j == 2) return {8'd64, r.proto, 16'h0000};
        if (j == ihl) return {16'h1234 ^ 16'(idx), 16'h5678 ^ 16'(idx)};
        if (r.proto == 8'd6) begin
            if (j == ihl + 1) return 32'h1000_0001;
            if (j == ihl + 2) return 32'h0000_0000;
            if (j == ihl + 3) return {r.doff, 12'h018, 16'hFFFF};
        end else if (j == ihl + 1) begin
            return {16'(8 + r.n_pay), 16'hABCD ^ 16'(idx)};
        end
        return 32'hEEEE_EEEE;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (io_out_udp_valid === 1'b1 && io_out_tcp_valid === 1'b1) begin
            errors++;
            $display("FAIL both_valid: got udp=1 tcp=1 expected at most one");
        end
    end

    task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n = 0;
        io_in_tdata = d; io_in_tkeep = k; io_in_tlast = l; io_in_tvalid = 1'b1;
        while (io_in_tready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (io_in_tready !== 1'b1) begin
            errors++; checks++;
            $display("FAIL beat_accept: got tready=%b expected 1 within 50 cycles", io_in_tready);
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic send_pkt(input vec_t r, input int idx, input int max_pay_beats);
        int nh, nb;
        logic [31:0] w;
        logic [3:0]  k;
        if (r.cut > 0) nh = r.cut;
        else if (r.proto == 8'd6) nh = int'(r.ihl) + ((r.doff < 4'd5) ? 5 : int'(r.doff));
        else nh = int'(r.ihl) + 2;
        nb = (r.n_pay + 3) / 4;
        if (nb > max_pay_beats) nb = max_pay_beats;
        for (int j = 0; j < nh; j++)
            drive_beat(hdr_word(r, j, idx), 4'hF, (j == nh - 1) && (r.n_pay == 0));
        for (int b = 0; b < nb; b++) begin
            w = '0; k = '0;
            for (int q = 0; q < 4; q++) begin
                if (4*b + q < r.n_pay) begin
                    w[31-8*q -: 8] = pay_byte(r, 4*b + q);
                    k[3-q] = 1'b1;
                end
            end
            drive_beat(w, k, (b == (r.n_pay + 3) / 4 - 1));
        end
        io_in_tvalid = 1'b0; io_in_tlast = 1'b0;
    endtask

    task automatic run_rec(input vec_t r, input int idx);
        logic [511:0] exp_d = '0;
        for (int b = 0; b < r.exp_len; b++) exp_d[511-8*b -: 8] = pay_byte(r, b);
        io_out_udp_ready = !r.exp_udp;
        io_out_tcp_ready = !r.exp_tcp;
        send_pkt(r, idx, 1000);
        chk($sformatf("v%0d udp_valid", idx), 512'(io_out_udp_valid), 512'(r.exp_udp));
        chk($sformatf("v%0d tcp_valid", idx), 512'(io_out_tcp_valid), 512'(r.exp_tcp));
        if (r.exp_udp || r.exp_tcp) begin
            chk($sformatf("v%0d tready_out", idx), 512'(io_in_tready), 512'(0));
            for (int h = 0; h <= r.hold; h++) begin
                if (h > 0) @(negedge clock);
                if (r.exp_udp) begin
                    chk($sformatf("v%0d udp_len c%0d", idx, h), 512'(io_out_udp_bits_len), 512'(r.exp_len));
                    chk($sformatf("v%0d udp_data c%0d", idx, h), io_out_udp_bits_data, exp_d);
                    chk($sformatf("v%0d udp_valid c%0d", idx, h), 512'(io_out_udp_valid), 512'(1));
                end else begin
                    chk($sformatf("v%0d tcp_len c%0d", idx, h), 512'(io_out_tcp_bits_len), 512'(r.exp_len));
                    chk($sformatf("v%0d tcp_data c%0d", idx, h), io_out_tcp_bits_data, exp_d);
                    chk($sformatf("v%0d tcp_valid c%0d", idx, h), 512'(io_out_tcp_valid), 512'(1));
                end
                if (h > 0) chk($sformatf("v%0d tready_hold c%0d", idx, h), 512'(io_in_tready), 512'(0));
            end
            if (r.exp_udp) begin
                chk($sformatf("v%0d src", idx), 512'(udp_src), 512'(16'h1234 ^ 16'(idx)));
                chk($sformatf("v%0d dst", idx), 512'(udp_dst), 512'(16'h5678 ^ 16'(idx)));
                chk($sformatf("v%0d length", idx), 512'(udp_length), 512'(16'(8 + r.n_pay)));
                chk($sformatf("v%0d csum", idx), 512'(udp_csum), 512'(16'hABCD ^ 16'(idx)));
                io_out_udp_ready = 1'b1;
            end else begin
                io_out_tcp_ready = 1'b1;
            end
            @(negedge clock);
            chk($sformatf("v%0d valid_drop", idx), 512'({io_out_udp_valid, io_out_tcp_valid}), 512'(0));
            chk($sformatf("v%0d tready_back", idx), 512'(io_in_tready), 512'(1));
            chk($sformatf("v%0d buf_clear", idx), io_out_udp_bits_data, 512'(0));
        end else begin
            for (int c = 0; c < 3; c++) begin
                chk($sformatf("v%0d no_record c%0d", idx, c), 512'({io_out_udp_valid, io_out_tcp_valid}), 512'(0));
                chk($sformatf("v%0d tready_drop c%0d", idx, c), 512'(io_in_tready), 512'(1));
                @(negedge clock);
            end
        end
        io_out_udp_ready = 1'b0;
        io_out_tcp_ready = 1'b0;
    endtask

    initial begin
        //          ver  ihl  proto doff  n  mode seed  fw  fw_word        hold cut udp tcp len
        tab[0]  = mk(4, 5, 8'd17, 0,  4, 0, 8'h00, 1, 32'hDEADBEEF, 0, 0, 1, 0, 4);
        tab[1]  = mk(4, 5, 8'd6,  5,  8, 0, 8'h01, 0, 32'h0,        0, 0, 0, 1, 8);
        tab[2]  = mk(4, 5, 8'd17, 0,  6, 1, 8'hEE, 0, 32'h0,        0, 0, 1, 0, 6);
        tab[3]  = mk(4, 5, 8'd17, 0,  4, 0, 8'h30, 0, 32'h0,        5, 0, 1, 0, 4);
        tab[4]  = mk(4, 7, 8'd17, 0,  5, 0, 8'h50, 0, 32'h0,        0, 0, 1, 0, 5);
        tab[5]  = mk(4, 6, 8'd6,  7,  3, 0, 8'h90, 0, 32'h0,        2, 0, 0, 1, 3);
        tab[6]  = mk(4, 5, 8'd17, 0, 80, 0, 8'h00, 0, 32'h0,        0, 0, 1, 0, 64);
        tab[7]  = mk(4, 5, 8'd6,  5,  0, 0, 8'h00, 0, 32'h0,        0, 0, 0, 1, 0);
        tab[8]  = mk(4, 5, 8'd17, 0,  0, 0, 8'h00, 0, 32'h0,        0, 0, 1, 0, 0);
        tab[9]  = mk(4, 5, 8'd1,  0,  8, 0, 8'h10, 0, 32'h0,        0, 0, 0, 0, 0);
        tab[10] = mk(6, 5, 8'd17, 0,  8, 0, 8'h10, 0, 32'h0,        0, 0, 0, 0, 0);
        tab[11] = mk(4, 4, 8'd17, 0,  8, 0, 8'h10, 0, 32'h0,        0, 0, 0, 0, 0);
        tab[12] = mk(4, 5, 8'd6,  3,  8, 0, 8'h10, 0, 32'h0,        0, 0, 0, 0, 0);
        tab[13] = mk(4, 5, 8'd17, 0,  0, 0, 8'h00, 0, 32'h0,        0, 4, 0, 0, 0);
        tab[14] = mk(4, 5, 8'd6,  5,  0, 0, 8'h00, 0, 32'h0,        0, 9, 0, 0, 0);
        tab[15] = mk(4, 5, 8'd17, 0,  2, 0, 8'hC0, 0, 32'h0,        0, 0, 1, 0, 2);

        reset = 1'b1;
        io_in_tvalid = 1'b0; io_in_tlast = 1'b0; io_in_tdata = '0; io_in_tkeep = '0;
        io_in_tstrb = '0; io_in_tid = '0; io_in_tdest = '0; io_in_tuser = '0;
        io_out_udp_ready = 1'b0; io_out_tcp_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("rst tready", 512'(io_in_tready), 512'(1));
        chk("rst valids", 512'({io_out_udp_valid, io_out_tcp_valid}), 512'(0));
        chk("rst udp_data", io_out_udp_bits_data, 512'(0));
        chk("rst tcp_len", 512'(io_out_tcp_bits_len), 512'(0));
        chk("rst udp_fields", 512'({udp_src, udp_dst, udp_length, udp_csum}), 512'(0));

        for (int i = 0; i < 16; i++) run_rec(tab[i], i);

        // version-1 garbage with tlast on beat 11: swallowed, tready never drops
        io_out_udp_ready = 1'b1; io_out_tcp_ready = 1'b1;
        for (int b = 0; b < 12; b++) begin
            chk($sformatf("drop tready b%0d", b), 512'(io_in_tready), 512'(1));
            drive_beat(32'h1234_5678, 4'hF, b == 11);
            chk($sformatf("drop no_record b%0d", b), 512'({io_out_udp_valid, io_out_tcp_valid}), 512'(0));
        end
        io_in_tvalid = 1'b0; io_in_tlast = 1'b0;
        run_rec(tab[0], 0);

        // reset mid-payload abandons the packet; next packet parses from word 0
        send_pkt(tab[6], 6, 3);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("midrst valids c%0d", c), 512'({io_out_udp_valid, io_out_tcp_valid}), 512'(0));
            chk($sformatf("midrst tready c%0d", c), 512'(io_in_tready), 512'(1));
            @(negedge clock);
        end
        chk("midrst len", 512'(io_out_udp_bits_len), 512'(0));
        run_rec(tab[1], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
